// File: rtl/write_back_register_file_pkg.sv
// Shared constants and types for the write-back stage and architectural register file.
package pipeline_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage : pipeline_pkg

// File: rtl/write_back_register_file_if.sv
// MEM/WB inputs, decode read ports and commit-observation outputs of the write-back stage.
// Handshake: no valid/ready pair; WriteBackEnableInput qualifies the MEM/WB bundle each cycle
// and WriteBackValid reports that the presented write commits on the coming rising edge.
interface write_back_register_file_if;
    import pipeline_pkg::*;

    logic        WriteBackEnableInput;
    logic        MemoryReadEnableInput;
    word_t       ALUResultInput;
    word_t       MemoryReadDataInput;
    reg_idx_t    DestinationRegisterInput;
    reg_idx_t    ReadRegisterA;
    reg_idx_t    ReadRegisterB;
    word_t       ReadDataA;
    word_t       ReadDataB;
    word_t       WriteBackData;
    logic        WriteBackValid;
    reg_idx_t    LastWriteRegister;
    word_t       LastWriteData;
    logic [31:0] CommitCount;

    modport master (
        output WriteBackEnableInput, MemoryReadEnableInput, ALUResultInput,
               MemoryReadDataInput, DestinationRegisterInput, ReadRegisterA, ReadRegisterB,
        input  ReadDataA, ReadDataB, WriteBackData, WriteBackValid,
               LastWriteRegister, LastWriteData, CommitCount
    );

    modport slave (
        input  WriteBackEnableInput, MemoryReadEnableInput, ALUResultInput,
               MemoryReadDataInput, DestinationRegisterInput, ReadRegisterA, ReadRegisterB,
        output ReadDataA, ReadDataB, WriteBackData, WriteBackValid,
               LastWriteRegister, LastWriteData, CommitCount
    );

endinterface : write_back_register_file_if

// File: rtl/write_back_register_file_register_array.sv
// Register storage: one synchronous write port, two raw combinational read ports, reset clear.
module register_array
    import pipeline_pkg::*;
(
    input  logic     clk,
    input  logic     Reset,
    input  logic     i_write_enable,
    input  reg_idx_t i_write_index,
    input  word_t    i_write_data,
    input  reg_idx_t i_read_index_a,
    input  reg_idx_t i_read_index_b,
    output word_t    o_read_data_a,
    output word_t    o_read_data_b
);

    word_t r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_write_enable) begin
            r_regs[i_write_index] <= i_write_data;
        end
    end

    assign o_read_data_a = r_regs[i_read_index_a];
    assign o_read_data_b = r_regs[i_read_index_b];

endmodule : register_array

// File: rtl/write_back_register_file.sv
// Write-back stage: source select, commit qualification, write-first bypass,
// last-write record and commit counter around the architectural register array.
module write_back_register_file
    import pipeline_pkg::*;
(
    input  logic                        clk,
    input  logic                        Reset,
    write_back_register_file_if.slave   bus
);

    word_t       w_wb_data;
    logic        w_commit;
    word_t       w_raw_a;
    word_t       w_raw_b;
    word_t       w_read_a;
    word_t       w_read_b;
    reg_idx_t    r_last_reg;
    word_t       r_last_data;
    logic [31:0] r_commit_count;

    assign w_wb_data = bus.MemoryReadEnableInput ? bus.MemoryReadDataInput : bus.ALUResultInput;

    // Gating with Reset also suppresses the bypass while the file is being cleared.
    assign w_commit = Reset && bus.WriteBackEnableInput &&
                      (bus.DestinationRegisterInput != ZERO_REG);

    register_array u_register_array (
        .clk            (clk),
        .Reset          (Reset),
        .i_write_enable (w_commit),
        .i_write_index  (bus.DestinationRegisterInput),
        .i_write_data   (w_wb_data),
        .i_read_index_a (bus.ReadRegisterA),
        .i_read_index_b (bus.ReadRegisterB),
        .o_read_data_a  (w_raw_a),
        .o_read_data_b  (w_raw_b)
    );

    always_comb begin
        w_read_a = w_raw_a;
        w_read_b = w_raw_b;
        if (bus.ReadRegisterA == ZERO_REG) begin
            w_read_a = '0;
        end else if (w_commit && (bus.ReadRegisterA == bus.DestinationRegisterInput)) begin
            w_read_a = w_wb_data;
        end
        if (bus.ReadRegisterB == ZERO_REG) begin
            w_read_b = '0;
        end else if (w_commit && (bus.ReadRegisterB == bus.DestinationRegisterInput)) begin
            w_read_b = w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_last_reg     <= '0;
            r_last_data    <= '0;
            r_commit_count <= '0;
        end else if (w_commit) begin
            r_last_reg     <= bus.DestinationRegisterInput;
            r_last_data    <= w_wb_data;
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign bus.ReadDataA         = w_read_a;
    assign bus.ReadDataB         = w_read_b;
    assign bus.WriteBackData     = w_wb_data;
    assign bus.WriteBackValid    = w_commit;
    assign bus.LastWriteRegister = r_last_reg;
    assign bus.LastWriteData     = r_last_data;
    assign bus.CommitCount       = r_commit_count;

endmodule : write_back_register_file

// File: tb/tb_write_back_register_file.sv
// Directed bench for write_back_register_file: inputs change on the falling edge, checks sit
// just after the falling edge (combinational view) or after the rising edge (registered view).
module tb_write_back_register_file;
    import pipeline_pkg::*;

    logic clk;
    logic Reset;
    int   checks;
    int   errors;

    write_back_register_file_if bus ();

    write_back_register_file dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic mrd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] dest,
                         input logic [4:0] ra, input logic [4:0] rb);
        bus.WriteBackEnableInput     = en;
        bus.MemoryReadEnableInput    = mrd;
        bus.ALUResultInput           = alu;
        bus.MemoryReadDataInput      = mem;
        bus.DestinationRegisterInput = dest;
        bus.ReadRegisterA            = ra;
        bus.ReadRegisterB            = rb;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held for two edges while a write to r5 is presented.
        Reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_AAAA, 32'h0, 5'd5, 5'd5, 5'd0);
        @(posedge clk);
        step();
        check("rst_valid", {31'b0, bus.WriteBackValid}, 32'h0);
        check("rst_bypass_a", bus.ReadDataA, 32'h0);
        check("rst_rd_b0", bus.ReadDataB, 32'h0);
        check("rst_count", bus.CommitCount, 32'h0);
        check("rst_lastreg", {27'b0, bus.LastWriteRegister}, 32'h0);
        check("rst_lastdata", bus.LastWriteData, 32'h0);
        Reset = 1'b1;
        bus.WriteBackEnableInput = 1'b0;
        step();
        check("rst_reg5", bus.ReadDataA, 32'h0);
        check("rst_count_after", bus.CommitCount, 32'h0);

        // ALU write to r3, visible through the bypass in the same cycle.
        drive(1'b1, 1'b0, 32'h0000_1234, 32'h0BAD_0BAD, 5'd3, 5'd3, 5'd0);
        #1;
        check("alu_valid", {31'b0, bus.WriteBackValid}, 32'h1);
        check("alu_wbdata", bus.WriteBackData, 32'h0000_1234);
        check("alu_bypass", bus.ReadDataA, 32'h0000_1234);
        step();
        // Load write to r4 while r3 is read from the array.
        drive(1'b1, 1'b1, 32'h0000_0999, 32'hDEAD_BEEF, 5'd4, 5'd3, 5'd4);
        #1;
        check("ld_wbdata", bus.WriteBackData, 32'hDEAD_BEEF);
        check("ld_r3_array", bus.ReadDataA, 32'h0000_1234);
        check("ld_bypass_b", bus.ReadDataB, 32'hDEAD_BEEF);
        check("ld_count_mid", bus.CommitCount, 32'd1);
        step();
        bus.WriteBackEnableInput = 1'b0;
        #1;
        check("ld_r3", bus.ReadDataA, 32'h0000_1234);
        check("ld_r4", bus.ReadDataB, 32'hDEAD_BEEF);
        check("ld_count", bus.CommitCount, 32'd2);
        check("ld_lastreg", {27'b0, bus.LastWriteRegister}, 32'd4);
        check("ld_lastdata", bus.LastWriteData, 32'hDEAD_BEEF);

        // Write to r0 is dropped.
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("z_valid", {31'b0, bus.WriteBackValid}, 32'h0);
        check("z_read", bus.ReadDataA, 32'h0);
        check("z_wbdata", bus.WriteBackData, 32'hFFFF_FFFF);
        step();
        check("z_read_after", bus.ReadDataA, 32'h0);
        check("z_count", bus.CommitCount, 32'd2);
        check("z_lastreg", {27'b0, bus.LastWriteRegister}, 32'd4);

        // Bypass: r7 = 0x11, then overwrite with 0x22 while both ports read r7.
        drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd7, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0000_0022, 32'h0, 5'd7, 5'd7, 5'd7);
        #1;
        check("byp_old_a", bus.ReadDataA, 32'h0000_0011);
        bus.WriteBackEnableInput = 1'b1;
        #1;
        check("byp_new_a", bus.ReadDataA, 32'h0000_0022);
        check("byp_new_b", bus.ReadDataB, 32'h0000_0022);
        step();
        bus.WriteBackEnableInput = 1'b0;
        #1;
        check("byp_arr_a", bus.ReadDataA, 32'h0000_0022);
        check("byp_arr_b", bus.ReadDataB, 32'h0000_0022);
        check("byp_count", bus.CommitCount, 32'd4);

        // Enable low: value is still selected but nothing commits.
        drive(1'b0, 1'b0, 32'h0000_0055, 32'h0000_0066, 5'd9, 5'd9, 5'd7);
        #1;
        check("en0_wbdata", bus.WriteBackData, 32'h0000_0055);
        check("en0_valid", {31'b0, bus.WriteBackValid}, 32'h0);
        check("en0_nobypass", bus.ReadDataA, 32'h0);
        step();
        check("en0_r9", bus.ReadDataA, 32'h0);
        check("en0_count", bus.CommitCount, 32'd4);

        // Counter wrap from 0xFFFF_FFFF.
        force dut.r_commit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_commit_count;
        #1;
        check("wrap_preload", bus.CommitCount, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 32'h0000_00A5, 32'h0, 5'd10, 5'd10, 5'd3);
        step();
        bus.WriteBackEnableInput = 1'b0;
        #1;
        check("wrap_count", bus.CommitCount, 32'h0);
        check("wrap_r10", bus.ReadDataA, 32'h0000_00A5);
        check("wrap_lastreg", {27'b0, bus.LastWriteRegister}, 32'd10);

        // Mid-run reset while committing r2: takes effect only at the edge.
        Reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd2, 5'd2, 5'd3);
        #1;
        check("mrst_valid", {31'b0, bus.WriteBackValid}, 32'h0);
        check("mrst_nobypass", bus.ReadDataA, 32'h0);
        check("mrst_r3_pre", bus.ReadDataB, 32'h0000_1234);
        step();
        Reset = 1'b1;
        bus.WriteBackEnableInput = 1'b0;
        #1;
        check("mrst_r2", bus.ReadDataA, 32'h0);
        check("mrst_r3", bus.ReadDataB, 32'h0);
        check("mrst_count", bus.CommitCount, 32'h0);
        check("mrst_lastreg", {27'b0, bus.LastWriteRegister}, 32'h0);
        check("mrst_lastdata", bus.LastWriteData, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_write_back_register_file

// File: doc/write_back_register_file.md
Name: write_back_register_file

Overview:
Write-back stage plus architectural register file. It consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result) and commits it to a 32x32 register array. It provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass. It also exposes a committed-write record and a commit counter for forwarding and verification.

Parameters:
DATA_WIDTH, 32, width of each register and of the write-back data
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, register count; must equal 2**ADDR_WIDTH

Ports:
clk  input  1  pipeline clock, all state updates on the rising edge
Reset  input  1  synchronous, active-low; Reset=0 at a rising edge of clk clears all state
WriteBackEnableInput  input  1  from MEM/WB: instruction writes a register
MemoryReadEnableInput  input  1  from MEM/WB: write-back source is memory (load)
ALUResultInput  input  DATA_WIDTH  from MEM/WB: ALU result
MemoryReadDataInput  input  DATA_WIDTH  from MEM/WB: data-memory read data
DestinationRegisterInput  input  ADDR_WIDTH  from MEM/WB: destination register index
ReadRegisterA  input  ADDR_WIDTH  decode read port A index
ReadRegisterB  input  ADDR_WIDTH  decode read port B index
ReadDataA  output  DATA_WIDTH  port A data, combinational
ReadDataB  output  DATA_WIDTH  port B data, combinational
WriteBackData  output  DATA_WIDTH  selected write-back value, combinational, for the forwarding unit
WriteBackValid  output  1  combinational; high when a write actually commits this cycle
LastWriteRegister  output  ADDR_WIDTH  registered index of the most recent committed write
LastWriteData  output  DATA_WIDTH  registered data of the most recent committed write
CommitCount  output  32  registered count of committed writes

Behaviour:
- Source select: WriteBackData = MemoryReadEnableInput ? MemoryReadDataInput : ALUResultInput. The selection is independent of the enable input.
- Commit condition: commit = Reset && WriteBackEnableInput && (DestinationRegisterInput != 0). WriteBackValid = commit.
- On the rising edge with commit: regs[DestinationRegisterInput] <= WriteBackData; LastWriteRegister/LastWriteData update; CommitCount += 1. CommitCount wraps modulo 2**32 (0xFFFFFFFF -> 0).
- Writes to register 0 are dropped: no array change, no counter increment, last-write record unchanged. Register 0 always reads 0.
- Read ports: combinational. If the read index is 0 -> 0. Else if WriteBackValid and the read index equals DestinationRegisterInput -> WriteBackData (write-first bypass). Else -> regs[index]. Both ports may hit the same register or the bypass simultaneously.
- Reset (Reset=0 at a rising edge): all NUM_REGS entries <= 0, LastWriteRegister <= 0, LastWriteData <= 0, CommitCount <= 0. A commit presented in the same cycle is discarded, and bypass is suppressed while Reset=0. Reset asserted mid-stream takes effect at the next edge only (synchronous).
- Latency: a write presented in cycle N is visible through the bypass in cycle N and from the array in cycle N+1 onward.
- No X on outputs after the first reset edge. Read indices are always in range because NUM_REGS = 2**ADDR_WIDTH.

Decomposition:
- Shared package pipeline_pkg: DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants; ZERO_REG = 0; typedefs reg_idx_t and word_t.
- One sub-module: register_array, holding the storage, one write port and two raw read ports, with reset clear. The top level holds the source mux, the commit logic, the bypass, the last-write record and the counter.

Test Plan:
- Reset: hold Reset=0 for 2 edges with WriteBackEnableInput=1, Dest=5 -> all ReadData=0, CommitCount=0, LastWriteRegister=0, and reg5 stays 0 after Reset=1.
- ALU write then load write: Dest=3, ALU=0x0000_1234, MemRead=0; next cycle Dest=4, Mem=0xDEAD_BEEF, MemRead=1 -> reg3=0x1234, reg4=0xDEADBEEF, CommitCount=2, LastWrite=(4, 0xDEADBEEF).
- Zero register: WB enable, Dest=0, ALU=0xFFFF_FFFF -> ReadDataA(idx 0)=0, WriteBackValid=0, CommitCount unchanged.
- Bypass: reg7 holds 0x11; present Dest=7, ALU=0x22, ReadRegisterA=ReadRegisterB=7 in the same cycle -> both ports read 0x22 that cycle and 0x22 from the array next cycle.
- Enable low: WriteBackEnableInput=0, Dest=9, ALU=0x55 -> reg9 unchanged, WriteBackData=0x55, WriteBackValid=0.
- Counter wrap and mid-run reset: force CommitCount to 0xFFFF_FFFF, commit once -> 0; then Reset=0 on an edge while committing Dest=2 -> reg2=0 and all records 0.
